// File: rtl/systolic_data_setup_if.sv
// Bundles the sequencer handshake, unified-buffer read port and the skewed
// activation stream of the systolic data setup block.
interface systolic_data_setup_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                          start;
  logic [ADDR_WIDTH-1:0]         base_addr;
  logic [ADDR_WIDTH:0]           row_count;
  logic                          busy;
  logic                          done;
  logic                          ub_enb;
  logic [ADDR_WIDTH-1:0]         ub_addrb;
  logic [LANES*DATA_WIDTH-1:0]   ub_doutb;
  logic                          out_valid;
  logic [LANES*DATA_WIDTH-1:0]   out_data;
  logic                          out_last;

  // Design side
  modport slave (
    input  start, base_addr, row_count, ub_doutb,
    output busy, done, ub_enb, ub_addrb, out_valid, out_data, out_last
  );

  // Sequencer / buffer / array side
  modport master (
    output start, base_addr, row_count, ub_doutb,
    input  busy, done, ub_enb, ub_addrb, out_valid, out_data, out_last
  );
endinterface

// File: rtl/systolic_data_setup.sv
// Streams a run of unified-buffer rows into the systolic array west edge,
// absorbing the 1-cycle BRAM latency and skewing lane j by j cycles.
module systolic_data_setup #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  systolic_data_setup_if.slave bus
);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic                  enb_q, enb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  enb_dly_q, enb_dly_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  // Bit i = lane i output stage holds row data (identical chain for every lane)
  logic [LANES-1:0]      vchain_q, vchain_d;
  logic                  last_now;

  // Final output cycle: only the last lane still carries data
  assign last_now = vchain_q[LANES-1] & ~(|vchain_q[LANES-2:0]);

  // Sequencer FSM: issue reads, wait for the skew window to drain, pulse done
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    enb_d       = 1'b0;
    addr_d      = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.row_count != '0)) begin
          state_d     = S_READ;
          enb_d       = 1'b1;
          addr_d      = bus.base_addr;
          remaining_d = bus.row_count - CNT_W'(1);
        end
      end
      S_READ: begin
        if (remaining_q != '0) begin
          enb_d       = 1'b1;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - CNT_W'(1);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_now) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Read-latency tracking and lane valid chain
  always_comb begin
    enb_dly_d   = enb_q;
    vchain_d    = {vchain_q[LANES-2:0], enb_dly_q};
    out_valid_d = |vchain_d;
    out_last_d  = vchain_d[LANES-1] & ~(|vchain_d[LANES-2:0]);
  end

  // Control and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      enb_q       <= 1'b0;
      addr_q      <= '0;
      enb_dly_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      vchain_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      enb_q       <= enb_d;
      addr_q      <= addr_d;
      enb_dly_q   <= enb_dly_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      vchain_q    <= vchain_d;
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] dat_q [j+1];
    logic [DATA_WIDTH-1:0] dat_d [j+1];

    // Capture the lane when the read is valid (zero otherwise), then delay j stages
    always_comb begin
      dat_d[0] = enb_dly_q ? bus.ub_doutb[j*DATA_WIDTH +: DATA_WIDTH] : '0;
      for (int i = 1; i <= j; i++) dat_d[i] = dat_q[i-1];
    end

    // Lane skew registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i <= j; i++) dat_q[i] <= '0;
      end else begin
        for (int i = 0; i <= j; i++) dat_q[i] <= dat_d[i];
      end
    end

    assign bus.out_data[j*DATA_WIDTH +: DATA_WIDTH] = dat_q[j];
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ub_enb    = enb_q;
  assign bus.ub_addrb  = addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_systolic_data_setup.sv
// Scoreboard bench for systolic_data_setup: a behavioural BRAM plus a
// reference model that predicts read addresses, the skewed output stream and
// the done cycle for each job.
module tb_systolic_data_setup;
  localparam int DW = 8;
  localparam int L  = 16;
  localparam int AW = 8;
  localparam int RW = L * DW;

  typedef struct {int c; logic [RW-1:0] d; bit last;} out_t;
  typedef struct {int c; int a;} adr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_data_setup_if #(.DATA_WIDTH(DW), .LANES(L), .ADDR_WIDTH(AW)) bus ();

  systolic_data_setup #(.DATA_WIDTH(DW), .LANES(L), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [RW-1:0] mem [256];
  out_t oq[$];
  adr_t aq[$];
  int   dq[$];
  int   cyc = 0;
  int   busy_lo = -1;
  int   busy_hi = -2;
  int   last_t0 = 0;
  int   vectors = 0;
  int   errors  = 0;
  bit   mon_en  = 1'b0;

  function automatic logic [RW-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // BRAM model: 1-cycle read latency, junk on the bus when not enabled
  always @(posedge clk) begin
    if (bus.ub_enb) bus.ub_doutb <= mem[bus.ub_addrb];
    else            bus.ub_doutb <= rand_row();
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_row(string nm, logic [RW-1:0] act, logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compare every DUT presentation against the queued predictions
  always @(negedge clk) begin : monitor
    adr_t a;
    out_t o;
    int   d;
    if (mon_en && !reset) begin
      if (bus.ub_enb) begin
        if (aq.size() == 0) chk_int("unexpected_ub_enb", 1, 0);
        else begin
          a = aq.pop_front();
          chk_int("rd_cycle", cyc, a.c);
          chk_int("rd_addr", int'(bus.ub_addrb), a.a);
        end
      end else if (aq.size() > 0 && aq[0].c < cyc) begin
        chk_int("missed_read", 0, 1);
        void'(aq.pop_front());
      end

      if (bus.out_valid) begin
        if (oq.size() == 0) begin
          chk_int("unexpected_out_valid", 1, 0);
          chk_row("stray_out_data", bus.out_data, '0);
        end else begin
          o = oq.pop_front();
          chk_int("out_cycle", cyc, o.c);
          chk_row("out_data", bus.out_data, o.d);
          chk_int("out_last", int'(bus.out_last), int'(o.last));
        end
      end else begin
        chk_row("idle_out_data", bus.out_data, '0);
        if (bus.out_last) chk_int("out_last_without_valid", 1, 0);
        if (oq.size() > 0 && oq[0].c < cyc) begin
          chk_int("missed_out_valid", 0, 1);
          void'(oq.pop_front());
        end
      end

      if (bus.done) begin
        if (dq.size() == 0) chk_int("unexpected_done", 1, 0);
        else begin
          d = dq.pop_front();
          chk_int("done_cycle", cyc, d);
        end
      end else if (dq.size() > 0 && dq[0] < cyc) begin
        chk_int("missed_done", 0, 1);
        void'(dq.pop_front());
      end

      chk_int("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  // Pulse start and enqueue the reference model's predictions for the job
  task automatic issue(int base, int count);
    logic [RW-1:0] d;
    logic [RW-1:0] row;
    int k;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.row_count = (AW+1)'(count);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    last_t0   = cyc;
    if (count == 0) return;
    for (int r = 0; r < count; r++) aq.push_back('{last_t0 + r, (base + r) % 256});
    for (int n = 3; n <= count + L + 1; n++) begin
      d = '0;
      for (int j = 0; j < L; j++) begin
        k = n - 3 - j;
        if (k >= 0 && k < count) begin
          row = mem[(base + k) % 256];
          d[j*DW +: DW] = row[j*DW +: DW];
        end
      end
      oq.push_back('{last_t0 + n - 1, d, n == count + L + 1});
    end
    dq.push_back(last_t0 + count + L + 1);
    busy_lo = last_t0;
    busy_hi = last_t0 + count + L + 1;
  endtask

  task automatic wait_idle(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (aq.size() == 0 && oq.size() == 0 && dq.size() == 0) return;
    end
    chk_int("job_timeout", 0, 1);
    aq.delete();
    oq.delete();
    dq.delete();
  endtask

  task automatic check_all_zero(string tag);
    chk_int({tag, "_busy"}, int'(bus.busy), 0);
    chk_int({tag, "_done"}, int'(bus.done), 0);
    chk_int({tag, "_ub_enb"}, int'(bus.ub_enb), 0);
    chk_int({tag, "_ub_addrb"}, int'(bus.ub_addrb), 0);
    chk_int({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk_int({tag, "_out_last"}, int'(bus.out_last), 0);
    chk_row({tag, "_out_data"}, bus.out_data, '0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [RW-1:0] row;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.row_count = '0;
    for (int a = 0; a < 256; a++) mem[a] = rand_row();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single row
    for (int j = 0; j < L; j++) row[j*DW +: DW] = DW'(8'h10 + j);
    mem[5] = row;
    issue(5, 1);
    wait_idle(60);

    // 16 rows, value r/2 - j
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j < L; j++) row[j*DW +: DW] = DW'(r / 2 - j);
      mem[r] = row;
    end
    issue(0, 16);
    wait_idle(80);

    // Address wrap, back-to-back with previous done
    issue(250, 10);
    wait_idle(60);

    // Start while busy is ignored
    issue(20, 4);
    while (cyc < last_t0 + 3) @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = AW'(7);
    bus.row_count = (AW+1)'(4);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(60);

    // Reset in the middle of a job
    issue(40, 16);
    while (cyc < last_t0 + 5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    aq.delete();
    oq.delete();
    dq.delete();
    busy_hi = -2;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    issue(100, 16);
    wait_idle(80);

    // Zero count start is ignored
    issue(3, 0);
    repeat (6) begin
      @(negedge clk);
      #1;
      chk_int("zero_count_busy", int'(bus.busy), 0);
    end

    // Full depth
    for (int a = 0; a < 256; a++) mem[a] = rand_row();
    issue(0, 256);
    wait_idle(320);

    // Randomized jobs
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 256; a++) mem[a] = rand_row();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(int'($urandom_range(0, 255)), int'($urandom_range(1, 40)));
      wait_idle(100);
    end

    repeat (4) @(negedge clk);
    chk_int("final_queues_empty", aq.size() + oq.size() + dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
